// File: rtl/lab3_pkg.sv
// Shared definitions for the lab 3 shifter / checker slice.
//   state_t   : checker FSM states (IDLE, HUNT, LOCKED), 2-bit encoded
//   DIR_LEFT  : direction code for rotate-left  (0)
//   DIR_RIGHT : direction code for rotate-right (1)
package lab3_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage : lab3_pkg

// File: rtl/lab3_4_rot_cmp.sv
// Combinational rotation comparator.
// Reports whether q_in is the one-step rotate-left or rotate-right of prev.
//   prev  in  WIDTH  reference sample
//   q_in  in  WIDTH  current sample
//   is_l  out 1      q_in == rol(prev)
//   is_r  out 1      q_in == ror(prev)
// Both flags are set together for rotation-symmetric patterns (0x00, 0xFF, 0x55...).
module lab3_4_rot_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] q_in,
    output logic             is_l,
    output logic             is_r
);

    logic [WIDTH-1:0] rol_prev;
    logic [WIDTH-1:0] ror_prev;

    assign rol_prev = {prev[WIDTH-2:0], prev[WIDTH-1]};
    assign ror_prev = {prev[0], prev[WIDTH-1:1]};

    assign is_l = (q_in == rol_prev);
    assign is_r = (q_in == ror_prev);

endmodule : lab3_4_rot_cmp

// File: rtl/lab3_4_shift_checker.sv
// Receive-side monitor for the rotating shifter pattern.
// Samples q_in on each sample_en strobe, locks onto a consistent rotate-left or
// rotate-right sequence, then tracks position in the rotation period and flags
// wrap events and mismatches.
//   clk        in   1              system clock
//   rst        in   1              synchronous reset, active-high
//   sample_en  in   1              one-cycle sample strobe
//   q_in       in   WIDTH          pattern bus under test
//   locked     out  1              sequence verified and being tracked
//   dir        out  1              0 = rotate-left, 1 = rotate-right (valid while locked)
//   pos        out  $clog2(WIDTH)  sample index within the rotation period
//   wrap       out  1              one-cycle pulse when pos wraps WIDTH-1 -> 0
//   err        out  1              one-cycle pulse on mismatch while locked
//   err_cnt    out  ERRW           saturating count of err pulses
module lab3_4_shift_checker
    import lab3_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LOCK_N = 4,
    parameter int ERRW   = 8,
    localparam int POSW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] q_in,
    output logic             locked,
    output logic             dir,
    output logic [POSW-1:0]  pos,
    output logic             wrap,
    output logic             err,
    output logic [ERRW-1:0]  err_cnt
);

    // Wide enough to hold LOCK_N itself.
    localparam int MCW = $clog2(LOCK_N + 1);
    localparam logic [MCW-1:0]  MC_LOCK = MCW'(LOCK_N);
    localparam logic [POSW-1:0] POS_MAX = POSW'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [MCW-1:0]    match_cnt_q, match_cnt_d;
    logic              cand_dir_q, cand_dir_d;
    logic              locked_q, locked_d;
    logic              dir_q, dir_d;
    logic [POSW-1:0]   pos_q, pos_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;
    logic [ERRW-1:0]   err_cnt_q, err_cnt_d;

    logic is_l;
    logic is_r;
    logic consistent;

    lab3_4_rot_cmp #(
        .WIDTH (WIDTH)
    ) u_rot_cmp (
        .prev (prev_q),
        .q_in (q_in),
        .is_l (is_l),
        .is_r (is_r)
    );

    // A symmetric pattern (is_l && is_r) satisfies either direction.
    assign consistent = (dir_q == DIR_LEFT) ? is_l : is_r;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        match_cnt_d = match_cnt_q;
        cand_dir_d  = cand_dir_q;
        locked_d    = locked_q;
        dir_d       = dir_q;
        pos_d       = pos_q;
        wrap_d      = 1'b0;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (sample_en) begin
            // Every sample becomes the reference for the next one, including
            // the sample that breaks a lock.
            prev_d = q_in;

            case (state_q)
                IDLE: begin
                    state_d = HUNT;
                end

                HUNT: begin
                    if (is_l && is_r) begin
                        // Symmetric: extends the run without choosing a direction.
                        match_cnt_d = match_cnt_q + MCW'(1);
                    end else if (is_l ^ is_r) begin
                        if ((match_cnt_q != '0) && (cand_dir_q == is_r)) begin
                            match_cnt_d = match_cnt_q + MCW'(1);
                        end else begin
                            cand_dir_d  = is_r;
                            match_cnt_d = MCW'(1);
                        end
                    end else begin
                        match_cnt_d = '0;
                    end

                    if (match_cnt_d >= MC_LOCK) begin
                        state_d     = LOCKED;
                        locked_d    = 1'b1;
                        dir_d       = cand_dir_d;
                        pos_d       = '0;
                        match_cnt_d = '0;
                    end
                end

                LOCKED: begin
                    if (consistent) begin
                        if (pos_q == POS_MAX) begin
                            pos_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            pos_d = pos_q + POSW'(1);
                        end
                    end else begin
                        err_d       = 1'b1;
                        locked_d    = 1'b0;
                        match_cnt_d = '0;
                        pos_d       = '0;
                        state_d     = HUNT;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERRW'(1);
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            match_cnt_q <= '0;
            cand_dir_q  <= DIR_LEFT;
            locked_q    <= 1'b0;
            dir_q       <= DIR_LEFT;
            pos_q       <= '0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            match_cnt_q <= match_cnt_d;
            cand_dir_q  <= cand_dir_d;
            locked_q    <= locked_d;
            dir_q       <= dir_d;
            pos_q       <= pos_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked  = locked_q;
    assign dir     = dir_q;
    assign pos     = pos_q;
    assign wrap    = wrap_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule : lab3_4_shift_checker
